// File: rtl/cu_pkg.sv
// Shared encodings, state type and decode bundle for the control unit.
// Imported by the decoder and the control_unit top.
package cu_pkg;

    localparam int STACK_DEPTH_DEF = 8;

    // Instruction class [18:17] and opcode [18:16]
    localparam logic [1:0] CLS_RALU = 2'b00;
    localparam logic [1:0] CLS_IALU = 2'b01;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_CTRL  = 3'b111;

    // Control sub-ops [15:14]
    localparam logic [1:0] SUB_JMP = 2'b00;
    localparam logic [1:0] SUB_JSB = 2'b01;
    localparam logic [1:0] SUB_RET = 2'b10;
    localparam logic [1:0] SUB_BR  = 2'b11;

    // Branch conditions [13:11]
    localparam logic [2:0] COND_BZ   = 3'b000;
    localparam logic [2:0] COND_BNZ  = 3'b001;
    localparam logic [2:0] COND_BC   = 3'b010;
    localparam logic [2:0] COND_BNC  = 3'b011;
    localparam logic [2:0] COND_HALT = 3'b111;

    // ALU functions
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_ADC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SBC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    // Datapath mux selects
    localparam logic [1:0] PCM_NEXT = 2'b00;
    localparam logic [1:0] PCM_BR   = 2'b01;
    localparam logic [1:0] PCM_JMP  = 2'b10;
    localparam logic [1:0] PCM_RET  = 2'b11;
    localparam logic [1:0] RWM_ALU   = 2'b00;
    localparam logic [1:0] RWM_SHIFT = 2'b01;
    localparam logic [1:0] RWM_MEM   = 2'b10;

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_HALT,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [1:0] pc_mux;
        logic [2:0] alu_op;
        logic [1:0] reg_write_mux;
        logic       reg_write;
        logic       mem_write;
        logic       push;
        logic       pop;
        logic       alu_use_carry;
        logic       alu_in_mux;
        logic       reg_B_mux;
        logic       select_c;
        logic       select_z;
        logic       write_c;
        logic       write_z;
        logic       is_lw;
        logic       is_halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Clear every state-changing strobe, keep the selects
    function automatic ctrl_t kill_strobes(ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_write = 1'b0;
        r.push      = 1'b0;
        r.pop       = 1'b0;
        r.write_c   = 1'b0;
        r.write_z   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/control_unit_inst_decoder.sv
// Pure combinational instruction decode.
// Branch conditions are resolved here against the live C/Z flags.
module inst_decoder
    import cu_pkg::*;
(
    input  logic [18:0] instruction,
    input  logic        C,
    input  logic        Z,
    output ctrl_t       ctrl
);

    logic [2:0] opc;
    logic [1:0] sub;
    logic [2:0] cond;
    logic       taken;
    logic       unused_bits;

    assign opc         = instruction[18:16];
    assign sub         = instruction[15:14];
    assign cond        = instruction[13:11];
    assign unused_bits = ^instruction[10:0];

    // Evaluate the branch condition on the current flags
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_BZ:  taken = Z;
            COND_BNZ: taken = ~Z;
            COND_BC:  taken = C;
            COND_BNC: taken = ~C;
            default:  taken = 1'b0;
        endcase
    end

    // Map opcode fields to datapath controls
    always_comb begin
        ctrl = CTRL_NOP;
        if (instruction[18] == 1'b0) begin
            ctrl.alu_op        = instruction[16:14];
            ctrl.alu_in_mux    = (instruction[18:17] == CLS_IALU);
            ctrl.reg_write     = 1'b1;
            ctrl.reg_write_mux = RWM_ALU;
            ctrl.alu_use_carry = (instruction[16:14] == ALU_ADC) ||
                                 (instruction[16:14] == ALU_SBC);
            ctrl.write_c       = ~instruction[16];
            ctrl.write_z       = 1'b1;
        end else begin
            unique case (opc)
                OP_LW: begin
                    ctrl.alu_in_mux    = 1'b1;
                    ctrl.alu_op        = ALU_ADD;
                    ctrl.reg_write     = 1'b1;
                    ctrl.reg_write_mux = RWM_MEM;
                    ctrl.is_lw         = 1'b1;
                end
                OP_SW: begin
                    ctrl.alu_in_mux = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.reg_B_mux  = 1'b1;
                    ctrl.mem_write  = 1'b1;
                end
                OP_SHIFT: begin
                    ctrl.reg_write     = 1'b1;
                    ctrl.reg_write_mux = RWM_SHIFT;
                    ctrl.select_c      = 1'b1;
                    ctrl.select_z      = 1'b1;
                    ctrl.write_c       = 1'b1;
                    ctrl.write_z       = 1'b1;
                end
                OP_CTRL: begin
                    unique case (sub)
                        SUB_JMP: ctrl.pc_mux = PCM_JMP;
                        SUB_JSB: begin
                            ctrl.pc_mux = PCM_JMP;
                            ctrl.push   = 1'b1;
                        end
                        SUB_RET: begin
                            ctrl.pc_mux = PCM_RET;
                            ctrl.pop    = 1'b1;
                        end
                        default: begin
                            ctrl.pc_mux  = taken ? PCM_BR : PCM_NEXT;
                            ctrl.is_halt = (cond == COND_HALT);
                        end
                    endcase
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Control unit: run/load/halt/error sequencing, return-stack depth
// tracking with overflow/underflow trap, and retired-instruction count.
module control_unit
    import cu_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [18:0]      instruction,
    input  logic             C,
    input  logic             Z,
    output logic             pc_en,
    output logic             mem_write,
    output logic             reg_write,
    output logic             push,
    output logic             pop,
    output logic             alu_use_carry,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_mux,
    output logic [1:0]       reg_write_mux,
    output logic             alu_in_mux,
    output logic             reg_B_mux,
    output logic             select_c,
    output logic             select_z,
    output logic             write_c,
    output logic             write_z,
    output logic             halted,
    output logic             stack_err,
    output logic [CNT_W-1:0] retired
);

    localparam int             DW   = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0]  FULL = DW'(STACK_DEPTH);

    state_t         state;
    state_t         nxt;
    logic [DW-1:0]  depth;
    logic [CNT_W-1:0] cnt;
    ctrl_t          dec;
    ctrl_t          ctl;
    logic           en;
    logic           trap;

    inst_decoder u_dec (
        .instruction (instruction),
        .C           (C),
        .Z           (Z),
        .ctrl        (dec)
    );

    assign trap = (dec.push && depth == FULL) ||
                  (dec.pop  && depth == '0);

    // State, stack depth and retired count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            depth <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (ctl.push)
                depth <= depth + 1'b1;
            else if (ctl.pop)
                depth <= depth - 1'b1;
            if (en)
                cnt <= cnt + 1'b1;
        end
    end

    // Next state and strobe gating
    always_comb begin
        nxt = state;
        en  = 1'b0;
        ctl = kill_strobes(dec);
        unique case (state)
            S_RUN: begin
                if (trap) begin
                    nxt = S_ERR;
                end else if (dec.is_lw) begin
                    nxt = S_LOAD;
                end else begin
                    ctl = dec;
                    en  = 1'b1;
                    if (dec.is_halt)
                        nxt = S_HALT;
                end
            end
            S_LOAD: begin
                ctl.reg_write     = 1'b1;
                ctl.reg_write_mux = RWM_MEM;
                en                = 1'b1;
                nxt               = S_RUN;
            end
            default: nxt = state;
        endcase
        if (reset) begin
            ctl = kill_strobes(dec);
            en  = 1'b0;
            nxt = S_RUN;
        end
    end

    assign pc_en         = en;
    assign mem_write     = ctl.mem_write;
    assign reg_write     = ctl.reg_write;
    assign push          = ctl.push;
    assign pop           = ctl.pop;
    assign alu_use_carry = ctl.alu_use_carry;
    assign alu_op        = ctl.alu_op;
    assign pc_mux        = ctl.pc_mux;
    assign reg_write_mux = ctl.reg_write_mux;
    assign alu_in_mux    = ctl.alu_in_mux;
    assign reg_B_mux     = ctl.reg_B_mux;
    assign select_c      = ctl.select_c;
    assign select_z      = ctl.select_z;
    assign write_c       = ctl.write_c;
    assign write_z       = ctl.write_z;
    assign halted        = (state == S_HALT) && !reset;
    assign stack_err     = (state == S_ERR) && !reset;
    assign retired       = cnt;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Retired counter narrowed to 4 bits so the wrap is reachable quickly.
module tb_control_unit;

    localparam int CW = 4;

    localparam logic [18:0] I_ADD  = 19'h00A60;
    localparam logic [18:0] I_ADCI = 19'h24000;
    localparam logic [18:0] I_NOT  = 19'h1C000;
    localparam logic [18:0] I_LW   = 19'h40A04;
    localparam logic [18:0] I_SW   = 19'h50000;
    localparam logic [18:0] I_SHF  = 19'h60000;
    localparam logic [18:0] I_BZ   = 19'h7C005;
    localparam logic [18:0] I_BC   = 19'h7D000;
    localparam logic [18:0] I_JMP  = 19'h70000;
    localparam logic [18:0] I_JSB  = 19'h74010;
    localparam logic [18:0] I_RET  = 19'h78000;
    localparam logic [18:0] I_HALT = 19'h7F800;

    logic          clk = 1'b0;
    logic          reset;
    logic [18:0]   instruction;
    logic          C, Z;
    logic          pc_en, mem_write, reg_write, push, pop, alu_use_carry;
    logic [2:0]    alu_op;
    logic [1:0]    pc_mux, reg_write_mux;
    logic          alu_in_mux, reg_B_mux, select_c, select_z;
    logic          write_c, write_z, halted, stack_err;
    logic [CW-1:0] retired;
    logic [6:0]    strb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // pc_en, reg_write, mem_write, push, pop, write_c, write_z
    assign strb = {pc_en, reg_write, mem_write, push, pop, write_c, write_z};

    control_unit #(.STACK_DEPTH(8), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .C(C), .Z(Z), .pc_en(pc_en), .mem_write(mem_write),
        .reg_write(reg_write), .push(push), .pop(pop),
        .alu_use_carry(alu_use_carry), .alu_op(alu_op),
        .pc_mux(pc_mux), .reg_write_mux(reg_write_mux),
        .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux),
        .select_c(select_c), .select_z(select_z),
        .write_c(write_c), .write_z(write_z),
        .halted(halted), .stack_err(stack_err), .retired(retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instruction = I_ADD;
        tick();
        n_chk++;
        if (strb !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", strb, 7'b0); end
        n_chk++;
        if ({halted, stack_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {halted, stack_err}); end
        n_chk++;
        if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        instruction = I_ADD;
        #1;
        n_chk++;
        if (strb !== 7'b1100011) begin n_fail++; $display("FAIL add_strobes: got %b want %b", strb, 7'b1100011); end
        n_chk++;
        if ({alu_op, alu_in_mux, pc_mux, reg_write_mux} !== 8'b000_0_00_00) begin
            n_fail++; $display("FAIL add_selects: got %b want 00000000", {alu_op, alu_in_mux, pc_mux, reg_write_mux});
        end
        tick();
        n_chk++;
        if (retired !== 4'd1) begin n_fail++; $display("FAIL add_retired: got %0d want 1", retired); end
        instruction = I_ADCI;
        #1;
        n_chk++;
        if ({alu_op, alu_in_mux, alu_use_carry, strb} !== {3'b001, 1'b1, 1'b1, 7'b1100011}) begin
            n_fail++; $display("FAIL adci_decode: got %b want %b", {alu_op, alu_in_mux, alu_use_carry, strb}, {3'b001, 1'b1, 1'b1, 7'b1100011});
        end
        tick();
        instruction = I_NOT;
        #1;
        n_chk++;
        if ({alu_op, alu_use_carry, select_c, select_z, strb} !== {3'b111, 3'b000, 7'b1100001}) begin
            n_fail++; $display("FAIL not_decode: got %b want %b", {alu_op, alu_use_carry, select_c, select_z, strb}, {3'b111, 3'b000, 7'b1100001});
        end
        tick();
        n_chk++;
        if (retired !== 4'd3) begin n_fail++; $display("FAIL alu_retired: got %0d want 3", retired); end
    endtask

    task automatic test_load();
        instruction = I_LW;
        #1;
        n_chk++;
        if ({strb, alu_in_mux, alu_op} !== {7'b0, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL lw_cycle1: got %b want %b", {strb, alu_in_mux, alu_op}, {7'b0, 1'b1, 3'b000});
        end
        tick();
        n_chk++;
        if ({strb, reg_write_mux, alu_in_mux} !== {7'b1100000, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL lw_cycle2: got %b want %b", {strb, reg_write_mux, alu_in_mux}, {7'b1100000, 2'b10, 1'b1});
        end
        n_chk++;
        if (retired !== 4'd3) begin n_fail++; $display("FAIL lw_retired_mid: got %0d want 3", retired); end
        tick();
        n_chk++;
        if (retired !== 4'd4) begin n_fail++; $display("FAIL lw_retired: got %0d want 4", retired); end
    endtask

    task automatic test_store_shift();
        instruction = I_SW;
        #1;
        n_chk++;
        if ({strb, reg_B_mux, alu_in_mux} !== {7'b1010000, 2'b11}) begin
            n_fail++; $display("FAIL sw_decode: got %b want %b", {strb, reg_B_mux, alu_in_mux}, {7'b1010000, 2'b11});
        end
        tick();
        instruction = I_SHF;
        #1;
        n_chk++;
        if ({strb, reg_write_mux, select_c, select_z} !== {7'b1100011, 2'b01, 2'b11}) begin
            n_fail++; $display("FAIL shift_decode: got %b want %b", {strb, reg_write_mux, select_c, select_z}, {7'b1100011, 2'b01, 2'b11});
        end
        tick();
        n_chk++;
        if (retired !== 4'd6) begin n_fail++; $display("FAIL sw_shift_retired: got %0d want 6", retired); end
    endtask

    task automatic test_branch();
        instruction = I_BZ;
        Z = 1'b1;
        #1;
        n_chk++;
        if ({pc_mux, strb} !== {2'b01, 7'b1000000}) begin
            n_fail++; $display("FAIL bz_taken: got %b want %b", {pc_mux, strb}, {2'b01, 7'b1000000});
        end
        Z = 1'b0;
        #1;
        n_chk++;
        if ({pc_mux, strb} !== {2'b00, 7'b1000000}) begin
            n_fail++; $display("FAIL bz_not_taken: got %b want %b", {pc_mux, strb}, {2'b00, 7'b1000000});
        end
        tick();
        instruction = I_BC;
        C = 1'b1;
        #1;
        n_chk++;
        if (pc_mux !== 2'b01) begin n_fail++; $display("FAIL bc_taken: got %b want 01", pc_mux); end
        C = 1'b0;
        #1;
        n_chk++;
        if (pc_mux !== 2'b00) begin n_fail++; $display("FAIL bc_not_taken: got %b want 00", pc_mux); end
        tick();
        instruction = I_JMP;
        #1;
        n_chk++;
        if ({pc_mux, strb} !== {2'b10, 7'b1000000}) begin
            n_fail++; $display("FAIL jmp: got %b want %b", {pc_mux, strb}, {2'b10, 7'b1000000});
        end
        tick();
        n_chk++;
        if (retired !== 4'd9) begin n_fail++; $display("FAIL branch_retired: got %0d want 9", retired); end
    endtask

    task automatic test_wrap();
        instruction = I_ADD;
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (retired !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d want 15", retired); end
        tick();
        n_chk++;
        if (retired !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", retired); end
        tick();
        n_chk++;
        if (retired !== 4'd1) begin n_fail++; $display("FAIL wrap_after: got %0d want 1", retired); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        instruction = I_JSB;
        #1;
        n_chk++;
        if ({pc_mux, strb} !== {2'b10, 7'b1001000}) begin
            n_fail++; $display("FAIL jsb: got %b want %b", {pc_mux, strb}, {2'b10, 7'b1001000});
        end
        tick();
        instruction = I_RET;
        #1;
        n_chk++;
        if ({pc_mux, strb} !== {2'b11, 7'b1000100}) begin
            n_fail++; $display("FAIL ret: got %b want %b", {pc_mux, strb}, {2'b11, 7'b1000100});
        end
        tick();
        n_chk++;
        if (strb !== 7'b0) begin n_fail++; $display("FAIL ret_underflow_strobes: got %b want 0000000", strb); end
        tick();
        n_chk++;
        if ({stack_err, strb, retired} !== {1'b1, 7'b0, 4'd2}) begin
            n_fail++; $display("FAIL b2b_err: got %b want %b", {stack_err, strb, retired}, {1'b1, 7'b0, 4'd2});
        end
    endtask

    task automatic test_ret_underflow();
        do_reset();
        instruction = I_RET;
        #1;
        n_chk++;
        if ({pop, pc_en, stack_err} !== 3'b000) begin
            n_fail++; $display("FAIL ret_first: got %b want 000", {pop, pc_en, stack_err});
        end
        tick();
        n_chk++;
        if ({stack_err, halted, retired} !== {2'b10, 4'd0}) begin
            n_fail++; $display("FAIL ret_err: got %b want %b", {stack_err, halted, retired}, {2'b10, 4'd0});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        instruction = I_JSB;
        for (int i = 0; i < 9; i++) begin
            #1;
            n_chk++;
            if ({push, pc_en, stack_err} !== {(i < 8), (i < 8), 1'b0}) begin
                n_fail++; $display("FAIL jsb_%0d: got %b want %b", i, {push, pc_en, stack_err}, {(i < 8), (i < 8), 1'b0});
            end
            tick();
        end
        instruction = I_ADD;
        tick();
        tick();
        n_chk++;
        if ({stack_err, strb, retired} !== {1'b1, 7'b0, 4'd8}) begin
            n_fail++; $display("FAIL overflow_hold: got %b want %b", {stack_err, strb, retired}, {1'b1, 7'b0, 4'd8});
        end
    endtask

    task automatic test_halt();
        do_reset();
        instruction = I_HALT;
        #1;
        n_chk++;
        if ({strb, pc_mux, halted} !== {7'b1000000, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL halt_decode: got %b want %b", {strb, pc_mux, halted}, {7'b1000000, 2'b00, 1'b0});
        end
        tick();
        instruction = I_ADD;
        #1;
        n_chk++;
        if ({halted, stack_err, strb, retired} !== {2'b10, 7'b0, 4'd1}) begin
            n_fail++; $display("FAIL halt_entry: got %b want %b", {halted, stack_err, strb, retired}, {2'b10, 7'b0, 4'd1});
        end
        tick();
        tick();
        n_chk++;
        if ({halted, strb, retired} !== {1'b1, 7'b0, 4'd1}) begin
            n_fail++; $display("FAIL halt_frozen: got %b want %b", {halted, strb, retired}, {1'b1, 7'b0, 4'd1});
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_mask: got %b want 0", halted); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_in_load();
        do_reset();
        instruction = I_ADD;
        tick();
        instruction = I_LW;
        tick();
        n_chk++;
        if (strb !== 7'b1100000) begin n_fail++; $display("FAIL load_state: got %b want 1100000", strb); end
        reset = 1'b1;
        #1;
        n_chk++;
        if (reg_write !== 1'b0) begin n_fail++; $display("FAIL load_reset_write: got %b want 0", reg_write); end
        tick();
        reset = 1'b0;
        instruction = I_ADD;
        #1;
        n_chk++;
        if ({strb, retired, halted, stack_err} !== {7'b1100011, 4'd0, 2'b00}) begin
            n_fail++; $display("FAIL load_reset_run: got %b want %b", {strb, retired, halted, stack_err}, {7'b1100011, 4'd0, 2'b00});
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction = '0;
        C = 1'b0;
        Z = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store_shift();
        test_branch();
        test_wrap();
        test_back_to_back();
        test_ret_underflow();
        test_overflow();
        test_halt();
        test_reset_in_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have these parameters: STACK_DEPTH, 8, depth of the datapath return stack; CNT_W, 16, width of the retired-instruction counter.
REQ-002 The module SHALL have these ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- instruction  in  19  current instruction from the datapath instruction memory.
- C, Z  in  1 each  datapath flag flip-flops.
- pc_en  out  1  datapath PC load enable.
- mem_write, reg_write, push, pop, alu_use_carry  out  1 each  datapath strobes and controls.
- alu_op  out  3  ALU function.
- pc_mux, reg_write_mux  out  2 each  datapath mux selects.
- alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z  out  1 each  datapath selects and flag write enables.
- halted  out  1  HALT state reached.
- stack_err  out  1  stack overflow or underflow trapped.
- retired  out  CNT_W  count of completed instructions.

Function
REQ-003 Decode SHALL use these fields: rd[13:11], rs[10:8], rt[7:5], imm8[7:0], addr12[11:0].
REQ-004 Class [18:17]=00 (R-ALU) SHALL decode as: alu_op=[16:14], alu_in_mux=0, reg_B_mux=0, reg_write=1, reg_write_mux=00.
REQ-005 Class [18:17]=01 (I-ALU) SHALL decode the same as R-ALU, except alu_in_mux=1.
REQ-006 ALU ops SHALL be 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 NOT-A.
REQ-007 For ALU ops, alu_use_carry SHALL be 1 only for ADC and SBC; write_c SHALL be 1 only for ops 000-011; write_z SHALL be 1; select_c=select_z=0.
REQ-008 [18:16]=100 (LW rd<-mem[rs+imm8]) SHALL be two-cycle:
- Cycle 1: alu_in_mux=1, alu_op=ADD, pc_en=0, state->LOAD.
- Cycle 2 (LOAD): same address controls, reg_write=1, reg_write_mux=10, pc_en=1, state->RUN.
REQ-009 [18:16]=101 (SW mem[rs+imm8]<-rd) SHALL drive alu_in_mux=1, alu_op=ADD, reg_B_mux=1, mem_write=1, single cycle.
REQ-010 [18:16]=110 (shift) SHALL drive reg_write=1, reg_write_mux=01, select_c=select_z=1, write_c=write_z=1; shift type and count are consumed by the datapath directly.
REQ-011 [18:16]=111 (control) SHALL decode on sub-op [15:14]:
- 00 JMP: pc_mux=10.
- 01 JSB: pc_mux=10, push=1.
- 10 RET: pc_mux=11, pop=1.
- 11 BR: condition [13:11] = 000 BZ, 001 BNZ, 010 BC, 011 BNC, 111 HALT, other values NOP.
REQ-012 BR SHALL select pc_mux=01 if the condition holds on the current C/Z, else pc_mux=00; all other instructions SHALL select pc_mux=00.
REQ-013 pc_en SHALL be 1 in RUN, except in cycle 1 of LW.
REQ-014 The state machine SHALL have states RUN, LOAD, HALT, ERR:
- HALT is entered when HALT is decoded in RUN.
- ERR is entered on a trap (REQ-015, REQ-016).
- HALT and ERR are left only by reset.
- In HALT and ERR, all strobes (pc_en, reg_write, mem_write, push, pop, write_c, write_z) SHALL be 0.
REQ-015 A depth counter (0..STACK_DEPTH) SHALL increment on an executed JSB and decrement on an executed RET; push and pop are never simultaneous.
REQ-016 JSB at depth=STACK_DEPTH, or RET at depth=0, SHALL suppress push/pop, pc_en and all writes for that cycle; the next state SHALL be ERR and stack_err=1.
REQ-017 retired SHALL increment once per completed instruction (each RUN cycle with pc_en=1, and each LOAD cycle), wrap from 2^CNT_W-1 to 0, and not increment in HALT or ERR; HALT itself SHALL count.
REQ-018 halted SHALL be 1 exactly in HALT, and stack_err SHALL be 1 exactly in ERR.

Reset
REQ-019 While reset=1 at a clock edge, the next state SHALL be RUN, with depth=0 and retired=0.
REQ-020 While reset=1, all strobe outputs SHALL be forced to 0, and halted=stack_err=0.
REQ-021 Reset in LOAD SHALL abandon the load with no register write.

Structure
REQ-022 Package cu_pkg SHALL hold: class/opcode/sub-op/condition codes, ALU op codes, pc_mux and reg_write_mux codes, the state enum, and the STACK_DEPTH default.
REQ-023 The pure combinational decode SHALL be a sub-module inst_decoder; control_unit SHALL hold the state, depth counter, retired counter, the trap logic and the strobe gating.

Verification
REQ-024 ADD r1,r2,r3 = 0x00A60 in RUN -> reg_write=1, alu_op=000, alu_in_mux=0, write_c=1, pc_en=1, pc_mux=00, retired +1.
REQ-025 LW r1,[r2+4] = 0x40A04 -> cycle 1: pc_en=0, reg_write=0; cycle 2: reg_write=1, reg_write_mux=10, pc_en=1; retired +1 total.
REQ-026 BZ +5 = 0x7C005 with Z=1 -> pc_mux=01; with Z=0 -> pc_mux=00; no other strobes.
REQ-027 Nine consecutive JSB 0x010 = 0x74010 -> push=1 on the first 8; on the 9th push=0 and pc_en=0, then stack_err=1 held until reset.
REQ-028 RET = 0x78000 immediately after reset -> pop=0, stack_err=1; then HALT = 0x7F800 after reset -> halted=1, all strobes 0, retired frozen.
REQ-029 reset asserted during LOAD of LW 0x40A04 -> no reg_write; state RUN and retired=0 after the edge.
